// File: rtl/mem_stage_wait.sv
// ============================================================================
// mem_stage_wait : registered MEM/WB boundary with a wait-stated data memory.
// Optional perf counters: define MEM_STAGE_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_wait #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int DEST_W      = 4,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN_IN,
  input  logic              MEM_R_EN_IN,
  input  logic              MEM_W_EN_IN,
  input  logic [DATA_W-1:0] ALU_Res_IN,
  input  logic [DATA_W-1:0] VAL_RM_IN,
  input  logic [DEST_W-1:0] Dest_IN,
  output logic              ready,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic [DATA_W-1:0] ALU_Res,
  output logic [DATA_W-1:0] DATA,
  output logic [DEST_W-1:0] Dest,
  output logic              ADDR_ERR
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       mem_op_cnt
`endif
);

  localparam int BYTE_LSB = $clog2(DATA_W / 8);
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = $clog2(WAIT_CYCLES + 1);

  localparam logic [1:0]        c_IDLE     = 2'd0;
  localparam logic [1:0]        c_ACCESS   = 2'd1;
  localparam logic [1:0]        c_DONE     = 2'd2;
  localparam logic [DATA_W-1:0] c_BASE     = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] c_DEPTH    = DATA_W'(DEPTH);
  localparam logic [CW-1:0]     c_CNT_LOAD = CW'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              w_req, w_load, w_mem_done, w_misalign, w_addr_err;
  logic [DATA_W-1:0] w_offset, w_index_full;
  logic [AW-1:0]     w_index;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign w_req        = MEM_R_EN_IN | MEM_W_EN_IN;
  // Both enables together behave as a store.
  assign w_load       = MEM_R_EN_IN & ~MEM_W_EN_IN;
  assign w_offset     = ALU_Res_IN - c_BASE;
  assign w_index_full = w_offset >> BYTE_LSB;
  assign w_index      = w_index_full[AW-1:0];
  assign w_mem_done   = (state_q == c_DONE);

  generate
    if (BYTE_LSB > 0) begin : g_align
      assign w_misalign = |w_offset[BYTE_LSB-1:0];
    end else begin : g_no_align
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_addr_err = (ALU_Res_IN < c_BASE) | w_misalign | (w_index_full >= c_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (w_req) begin
          state_d = c_ACCESS;
          cnt_d   = c_CNT_LOAD;
        end
      end
      c_ACCESS: begin
        if (cnt_q == '0) state_d = c_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (state_q)
      c_IDLE:  ready = ~w_req;
      c_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // While stalled the register holds a bubble; payload fields keep their values.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      ALU_Res  <= '0;
      DATA     <= '0;
      Dest     <= '0;
      ADDR_ERR <= 1'b0;
    end else if (ready) begin
      WB_EN   <= WB_EN_IN;
      ALU_Res <= ALU_Res_IN;
      Dest    <= Dest_IN;
      if (w_mem_done) begin
        MEM_R_EN <= w_load;
        DATA     <= (w_load && !w_addr_err) ? mem_q[w_index] : '0;
        ADDR_ERR <= w_addr_err;
      end else begin
        MEM_R_EN <= 1'b0;
        DATA     <= '0;
        ADDR_ERR <= 1'b0;
      end
    end else begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      ADDR_ERR <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_mem_done && MEM_W_EN_IN && !w_addr_err) begin
      mem_q[w_index] <= VAL_RM_IN;
    end
  end

`ifdef MEM_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      mem_op_cnt <= '0;
    end else begin
      if (!ready)     stall_cnt  <= stall_cnt + 32'd1;
      if (w_mem_done) mem_op_cnt <= mem_op_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_wait.sv
// ============================================================================
// tb_mem_stage_wait : directed and randomized bench with a word-array memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_wait;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 64;
  localparam int DEST_W      = 4;
  localparam int BASE_ADDR   = 1024;
  localparam int WAIT_CYCLES = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
  logic [DATA_W-1:0] ALU_Res_IN, VAL_RM_IN;
  logic [DEST_W-1:0] Dest_IN;
  logic              ready, WB_EN, MEM_R_EN, ADDR_ERR;
  logic [DATA_W-1:0] ALU_Res, DATA;
  logic [DEST_W-1:0] Dest;
`ifdef MEM_STAGE_PERF_EN
  logic [31:0]       stall_cnt, mem_op_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                model_vld [DEPTH];
  logic [DATA_W-1:0] prev_alu;
  logic [DEST_W-1:0] prev_dest;

  always #5 clk = ~clk;

  mem_stage_wait #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DEST_W(DEST_W),
    .BASE_ADDR(BASE_ADDR), .WAIT_CYCLES(WAIT_CYCLES)
  ) u_dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .ALU_Res_IN(ALU_Res_IN), .VAL_RM_IN(VAL_RM_IN), .Dest_IN(Dest_IN),
    .ready(ready), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .ALU_Res(ALU_Res), .DATA(DATA), .Dest(Dest), .ADDR_ERR(ADDR_ERR)
`ifdef MEM_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .mem_op_cnt(mem_op_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit addr_bad(input logic [DATA_W-1:0] a);
    longint off;
    off = longint'(a) - longint'(BASE_ADDR);
    if (off < 0) return 1'b1;
    if (off % (DATA_W / 8) != 0) return 1'b1;
    if (off / (DATA_W / 8) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit wb, input bit re, input bit we,
                       input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                       input logic [DEST_W-1:0] dest);
    WB_EN_IN    = wb;
    MEM_R_EN_IN = re;
    MEM_W_EN_IN = we;
    ALU_Res_IN  = addr;
    VAL_RM_IN   = wdata;
    Dest_IN     = dest;
  endtask

  // Present one instruction (called just after a clock edge) and check it through retirement.
  task automatic op(input bit wb, input bit re, input bit we,
                    input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                    input logic [DEST_W-1:0] dest);
    int  stalls;
    bit  done, mem, err, ld;
    int  idx;
    mem    = re | we;
    err    = mem && addr_bad(addr);
    ld     = re && !we;
    idx    = err ? 0 : int'((longint'(addr) - BASE_ADDR) / (DATA_W / 8));
    stalls = 0;
    done   = 1'b0;
    drive(wb, re, we, addr, wdata, dest);
    while (!done) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk); #1;
        chk("bubble_wb_en", WB_EN, 0);
        chk("bubble_mem_r_en", MEM_R_EN, 0);
        chk("bubble_addr_err", ADDR_ERR, 0);
        chk("hold_alu_res", ALU_Res, prev_alu);
        chk("hold_dest", Dest, prev_dest);
        if (stalls > 3 * WAIT_CYCLES + 10) begin
          chk("ready_timeout", stalls, WAIT_CYCLES + 1);
          done = 1'b1;
        end
      end
    end
    chk("stall_len", stalls, mem ? WAIT_CYCLES + 1 : 0);
    chk("wb_en", WB_EN, wb);
    chk("mem_r_en", MEM_R_EN, ld);
    chk("alu_res", ALU_Res, addr);
    chk("dest", Dest, dest);
    chk("addr_err", ADDR_ERR, err);
    if (ld && !err) begin
      if (model_vld[idx]) chk("load_data", DATA, model_mem[idx]);
    end else begin
      chk("data_zero", DATA, 0);
    end
    if (we && !err) begin
      model_mem[idx] = wdata;
      model_vld[idx] = 1'b1;
    end
    prev_alu  = addr;
    prev_dest = dest;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    foreach (model_vld[i]) model_vld[i] = 1'b0;
    prev_alu  = '0;
    prev_dest = '0;

    // Reset with live inputs: outputs must still clear.
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd9);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_en", WB_EN, 0);
    chk("rst_alu_res", ALU_Res, 0);
    chk("rst_dest", Dest, 0);
    chk("rst_data", DATA, 0);
    chk("rst_addr_err", ADDR_ERR, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    @(posedge clk); #1;

    // Non-memory op, store/load round trip, and range boundaries.
    op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
    op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd1);
    op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd2);
`ifdef MEM_STAGE_PERF_EN
    chk("perf_stall_cnt", stall_cnt, 10);
    chk("perf_mem_op_cnt", mem_op_cnt, 2);
`endif
    op(1'b0, 1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, 4'd0);
    op(1'b1, 1'b1, 1'b0, 32'd1276, 32'h0, 4'd5);
    op(1'b1, 1'b1, 1'b0, 32'd1280, 32'h0, 4'd4);
    op(1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 4'd4);
    op(1'b1, 1'b1, 1'b0, 32'd1026, 32'h0, 4'd4);
    op(1'b0, 1'b0, 1'b1, 32'd1280, 32'h11111111, 4'd0);
    op(1'b1, 1'b1, 1'b1, 32'd1040, 32'h1234, 4'd6);
    op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd6);

    // Reset asserted in the DONE cycle of a store must abort it.
    op(1'b0, 1'b0, 1'b1, 32'd1048, 32'h5555, 4'd0);
    drive(1'b1, 1'b0, 1'b1, 32'd1048, 32'hAAAA, 4'd7);
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 3 * WAIT_CYCLES + 10) begin
      guard++;
      @(negedge clk);
    end
    chk("abort_reach_done", guard, WAIT_CYCLES + 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    chk("abort_wb_en", WB_EN, 0);
    chk("abort_alu_res", ALU_Res, 0);
    chk("abort_dest", Dest, 0);
    chk("abort_addr_err", ADDR_ERR, 0);
    @(negedge clk);
    chk("abort_ready", ready, 1);
    @(posedge clk); #1;
    prev_alu  = '0;
    prev_dest = '0;
    op(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, 4'd8);

    // Randomized mix of ALU ops, loads, stores and bad addresses.
    for (int n = 0; n < 150; n++) begin
      int unsigned kind, sel;
      logic [DATA_W-1:0] a;
      bit re, we;
      kind = $urandom_range(0, 9);
      sel  = $urandom_range(0, 9);
      if (sel < 7)       a = BASE_ADDR + 4 * $urandom_range(0, DEPTH - 1);
      else if (sel == 7) a = BASE_ADDR + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else if (sel == 8) a = ($urandom_range(0, 1) != 0) ? BASE_ADDR - 4 : BASE_ADDR + 4 * DEPTH;
      else               a = $urandom;
      if (kind < 3) begin
        re = 1'b0;
        we = 1'b0;
      end else begin
        re = ($urandom_range(0, 2) != 0);
        we = !re || ($urandom_range(0, 4) == 0);
      end
      op(1'($urandom), re, we, a, $urandom, DEST_W'($urandom));
    end

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
